// File: rtl/dispatch_busytable.sv
// Dispatch stage between rename and the issue queue: a 2-entry FIFO of renamed
// instructions plus a per-physical-register busy table that supplies operand readiness.
module dispatch_busytable #(
  parameter int PREG_NUM  = 64,
  parameter int PREG_W    = 6,
  parameter int PAYLOAD_W = 256
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PREG_W-1:0]    in_prs1,
  input  logic [PREG_W-1:0]    in_prs2,
  input  logic [PREG_W-1:0]    in_prd,
  input  logic                 in_src1_is_reg,
  input  logic                 in_src2_is_reg,
  input  logic                 in_need_to_wb,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 iq_valid,
  input  logic                 iq_ready,
  output logic [PREG_W-1:0]    iq_prs1,
  output logic [PREG_W-1:0]    iq_prs2,
  output logic [PREG_W-1:0]    iq_prd,
  output logic                 iq_src1_is_reg,
  output logic                 iq_src2_is_reg,
  output logic                 iq_need_to_wb,
  output logic                 iq_src1_state,
  output logic                 iq_src2_state,
  output logic [PAYLOAD_W-1:0] iq_payload,
  input  logic                 writeback0_valid,
  input  logic                 writeback0_need_to_wb,
  input  logic [PREG_W-1:0]    writeback0_prd,
  input  logic                 writeback1_valid,
  input  logic                 writeback1_need_to_wb,
  input  logic [PREG_W-1:0]    writeback1_prd,
  input  logic                 flush
);

  logic [PREG_NUM-1:0]  busy;
  logic [PREG_NUM-1:0]  busy_nxt;
  logic [1:0]           count;
  logic                 wr_ptr;
  logic                 rd_ptr;

  logic [PREG_W-1:0]    prs1_q [2];
  logic [PREG_W-1:0]    prs2_q [2];
  logic [PREG_W-1:0]    prd_q  [2];
  logic [PAYLOAD_W-1:0] payload_q [2];
  logic [1:0]           src1_is_reg_q;
  logic [1:0]           src2_is_reg_q;
  logic [1:0]           need_to_wb_q;
  logic [1:0]           src1_state_q;
  logic [1:0]           src2_state_q;

  logic wb0_hit;
  logic wb1_hit;
  logic accept;
  logic deq;
  logic src1_state_in;
  logic src2_state_in;

  function automatic logic woken(input logic [PREG_W-1:0] prs,
                                 input logic h0, input logic [PREG_W-1:0] p0,
                                 input logic h1, input logic [PREG_W-1:0] p1);
    woken = (h0 && (p0 == prs)) || (h1 && (p1 == prs));
  endfunction

  assign wb0_hit  = writeback0_valid & writeback0_need_to_wb & (writeback0_prd != '0);
  assign wb1_hit  = writeback1_valid & writeback1_need_to_wb & (writeback1_prd != '0);
  assign in_ready = (count < 2'd2);
  assign iq_valid = (count != 2'd0);
  assign accept   = in_valid & in_ready;
  assign deq      = iq_valid & iq_ready;

  // A writeback landing in the accept cycle must not leave the operand marked pending
  assign src1_state_in = in_src1_is_reg & (in_prs1 != '0) & busy[in_prs1] &
                         ~woken(in_prs1, wb0_hit, writeback0_prd, wb1_hit, writeback1_prd);
  assign src2_state_in = in_src2_is_reg & (in_prs2 != '0) & busy[in_prs2] &
                         ~woken(in_prs2, wb0_hit, writeback0_prd, wb1_hit, writeback1_prd);

  // Clears first so a same-cycle set on the same register wins
  always_comb begin
    busy_nxt = busy;
    if (wb0_hit) busy_nxt[writeback0_prd] = 1'b0;
    if (wb1_hit) busy_nxt[writeback1_prd] = 1'b0;
    if (accept && !flush && in_need_to_wb && (in_prd != '0)) busy_nxt[in_prd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy   <= '0;
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      busy <= busy_nxt;
      if (flush) begin
        count  <= 2'd0;
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
      end else begin
        if (accept) wr_ptr <= ~wr_ptr;
        if (deq)    rd_ptr <= ~rd_ptr;
        count <= count + 2'(accept) - 2'(deq);
      end
    end
  end

  // Entry storage: wakeups on buffered entries, then the write of a newly accepted entry
  always_ff @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      src1_state_q[i] <= src1_state_q[i] & ~(src1_is_reg_q[i] &
                         woken(prs1_q[i], wb0_hit, writeback0_prd, wb1_hit, writeback1_prd));
      src2_state_q[i] <= src2_state_q[i] & ~(src2_is_reg_q[i] &
                         woken(prs2_q[i], wb0_hit, writeback0_prd, wb1_hit, writeback1_prd));
    end
    if (accept && !flush) begin
      prs1_q[wr_ptr]        <= in_prs1;
      prs2_q[wr_ptr]        <= in_prs2;
      prd_q[wr_ptr]         <= in_prd;
      payload_q[wr_ptr]     <= in_payload;
      src1_is_reg_q[wr_ptr] <= in_src1_is_reg;
      src2_is_reg_q[wr_ptr] <= in_src2_is_reg;
      need_to_wb_q[wr_ptr]  <= in_need_to_wb;
      src1_state_q[wr_ptr]  <= src1_state_in;
      src2_state_q[wr_ptr]  <= src2_state_in;
    end
  end

  // Head fields are gated to zero while empty; the issue queue latches on the same edge
  // it processes wakeups, so a wakeup this cycle is masked out of the presented state.
  always_comb begin
    iq_prs1        = '0;
    iq_prs2        = '0;
    iq_prd         = '0;
    iq_payload     = '0;
    iq_src1_is_reg = 1'b0;
    iq_src2_is_reg = 1'b0;
    iq_need_to_wb  = 1'b0;
    iq_src1_state  = 1'b0;
    iq_src2_state  = 1'b0;
    if (iq_valid) begin
      iq_prs1        = prs1_q[rd_ptr];
      iq_prs2        = prs2_q[rd_ptr];
      iq_prd         = prd_q[rd_ptr];
      iq_payload     = payload_q[rd_ptr];
      iq_src1_is_reg = src1_is_reg_q[rd_ptr];
      iq_src2_is_reg = src2_is_reg_q[rd_ptr];
      iq_need_to_wb  = need_to_wb_q[rd_ptr];
      iq_src1_state  = src1_state_q[rd_ptr] &
                       ~woken(prs1_q[rd_ptr], wb0_hit, writeback0_prd, wb1_hit, writeback1_prd);
      iq_src2_state  = src2_state_q[rd_ptr] &
                       ~woken(prs2_q[rd_ptr], wb0_hit, writeback0_prd, wb1_hit, writeback1_prd);
    end
  end

endmodule

// File: tb/tb_dispatch_busytable.sv
// Randomized scoreboard bench for dispatch_busytable with a queue/array reference model.
module tb_dispatch_busytable;

  logic         clock;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [5:0]   in_prs1, in_prs2, in_prd;
  logic         in_src1_is_reg, in_src2_is_reg, in_need_to_wb;
  logic [255:0] in_payload;
  logic         iq_valid, iq_ready;
  logic [5:0]   iq_prs1, iq_prs2, iq_prd;
  logic         iq_src1_is_reg, iq_src2_is_reg, iq_need_to_wb;
  logic         iq_src1_state, iq_src2_state;
  logic [255:0] iq_payload;
  logic         writeback0_valid, writeback0_need_to_wb;
  logic [5:0]   writeback0_prd;
  logic         writeback1_valid, writeback1_need_to_wb;
  logic [5:0]   writeback1_prd;
  logic         flush;

  dispatch_busytable dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_prs1(in_prs1), .in_prs2(in_prs2), .in_prd(in_prd),
    .in_src1_is_reg(in_src1_is_reg), .in_src2_is_reg(in_src2_is_reg),
    .in_need_to_wb(in_need_to_wb), .in_payload(in_payload),
    .iq_valid(iq_valid), .iq_ready(iq_ready),
    .iq_prs1(iq_prs1), .iq_prs2(iq_prs2), .iq_prd(iq_prd),
    .iq_src1_is_reg(iq_src1_is_reg), .iq_src2_is_reg(iq_src2_is_reg),
    .iq_need_to_wb(iq_need_to_wb),
    .iq_src1_state(iq_src1_state), .iq_src2_state(iq_src2_state),
    .iq_payload(iq_payload),
    .writeback0_valid(writeback0_valid), .writeback0_need_to_wb(writeback0_need_to_wb),
    .writeback0_prd(writeback0_prd),
    .writeback1_valid(writeback1_valid), .writeback1_need_to_wb(writeback1_need_to_wb),
    .writeback1_prd(writeback1_prd),
    .flush(flush)
  );

  typedef struct {
    logic [5:0]   p1, p2, pd;
    logic         r1, r2, nw, s1, s2;
    logic [255:0] pl;
  } ent_t;

  ent_t        q[$];
  logic [63:0] busy_m;
  int          checks = 0;
  int          errors = 0;
  bit          started = 0;
  bit          last_rst = 0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic hit_on(input logic [5:0] prs);
    logic h0, h1;
    h0 = writeback0_valid && writeback0_need_to_wb && (writeback0_prd != 0);
    h1 = writeback1_valid && writeback1_need_to_wb && (writeback1_prd != 0);
    return (h0 && writeback0_prd == prs) || (h1 && writeback1_prd == prs);
  endfunction

  // Monitor: compares presented outputs against the model head, pops on handshake
  always @(negedge clock) begin
    #2;
    if (started) begin
      chk("in_ready", in_ready, q.size() < 2);
      chk("count", dut.count, q.size());
      chk("busy", dut.busy, busy_m);
      if (q.size() == 0) begin
        chk("iq_valid_empty", iq_valid, 1'b0);
        if (last_rst) begin
          chk("reset_iq_fields", {iq_prs1, iq_prs2, iq_prd, iq_src1_is_reg, iq_src2_is_reg,
                                  iq_need_to_wb, iq_src1_state, iq_src2_state}, '0);
          chk("reset_iq_payload", iq_payload, '0);
        end
      end else begin
        ent_t e;
        e = q[0];
        chk("iq_valid", iq_valid, 1'b1);
        chk("iq_prs1", iq_prs1, e.p1);
        chk("iq_prs2", iq_prs2, e.p2);
        chk("iq_prd", iq_prd, e.pd);
        chk("iq_flags", {iq_src1_is_reg, iq_src2_is_reg, iq_need_to_wb}, {e.r1, e.r2, e.nw});
        chk("iq_src1_state", iq_src1_state, e.s1 && !hit_on(e.p1));
        chk("iq_src2_state", iq_src2_state, e.s2 && !hit_on(e.p2));
        chk("iq_payload", iq_payload, e.pl);
        if (iq_ready) void'(q.pop_front());
      end
      foreach (q[i]) begin
        if (q[i].r1 && hit_on(q[i].p1)) q[i].s1 = 1'b0;
        if (q[i].r2 && hit_on(q[i].p2)) q[i].s2 = 1'b0;
      end
    end
  end

  // Driver: applies one cycle of stimulus and pushes the expected entry on accept
  task automatic cycle(input logic rs, input logic iv, input logic [5:0] p1, p2, pd,
                       input logic r1, r2, nw, input logic iqr,
                       input logic w0v, w0n, input logic [5:0] w0p,
                       input logic w1v, w1n, input logic [5:0] w1p, input logic fl);
    int   sz0;
    logic acc;
    ent_t e;
    @(negedge clock);
    sz0 = q.size();
    reset = rs; in_valid = iv; in_prs1 = p1; in_prs2 = p2; in_prd = pd;
    in_src1_is_reg = r1; in_src2_is_reg = r2; in_need_to_wb = nw;
    in_payload = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    iq_ready = iqr;
    writeback0_valid = w0v; writeback0_need_to_wb = w0n; writeback0_prd = w0p;
    writeback1_valid = w1v; writeback1_need_to_wb = w1n; writeback1_prd = w1p;
    flush = fl;
    #3;
    if (rs) begin
      q.delete();
      busy_m = '0;
    end else begin
      acc = iv && (sz0 < 2) && !fl;
      if (acc) begin
        e.p1 = p1; e.p2 = p2; e.pd = pd; e.r1 = r1; e.r2 = r2; e.nw = nw; e.pl = in_payload;
        e.s1 = r1 && (p1 != 0) && busy_m[p1] && !hit_on(p1);
        e.s2 = r2 && (p2 != 0) && busy_m[p2] && !hit_on(p2);
        q.push_back(e);
      end
      if (w0v && w0n && w0p != 0) busy_m[w0p] = 1'b0;
      if (w1v && w1n && w1p != 0) busy_m[w1p] = 1'b0;
      if (acc && nw && pd != 0) busy_m[pd] = 1'b1;
      if (fl) q.delete();
    end
    last_rst = rs;
    if (rs) started = 1'b1;
  endtask

  task automatic drive(input logic iv, input logic [5:0] p1, p2, pd, input logic iqr,
                       input logic [5:0] w0p, w1p, input logic fl, input logic rs);
    cycle(rs, iv, p1, p2, pd, 1'b1, 1'b1, 1'b1, iqr,
          w0p != 0, w0p != 0, w0p, w1p != 0, w1p != 0, w1p, fl);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_prs1 = '0; in_prs2 = '0; in_prd = '0;
    in_src1_is_reg = 1'b0; in_src2_is_reg = 1'b0; in_need_to_wb = 1'b0; in_payload = '0;
    iq_ready = 1'b0; writeback0_valid = 1'b0; writeback0_need_to_wb = 1'b0;
    writeback0_prd = '0; writeback1_valid = 1'b0; writeback1_need_to_wb = 1'b0;
    writeback1_prd = '0; flush = 1'b0; busy_m = '0;

    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    // Basic accept, dependent instruction, wakeup while held
    drive(1, 5, 0, 7, 0, 0, 0, 0, 0);
    drive(1, 7, 0, 3, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 7, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
    // Head with pending src1 woken by port 1 in the presentation cycle
    drive(1, 0, 0, 7, 1, 0, 0, 0, 0);
    drive(1, 7, 0, 4, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 7, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
    // Backpressure, then drain six through the pointer wrap
    for (int i = 0; i < 3; i++) drive(1, 6'(i), 6'(i + 1), 6'(20 + i), 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) drive(1, 6'(i + 1), 6'(i), 6'(30 + i), 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
    // Set beats same-cycle clear, prd=0, prs1=0
    drive(1, 0, 0, 9, 1, 9, 0, 0, 0);
    drive(1, 0, 0, 0, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
    // Flush with a coincident accept, then mid-stream reset
    drive(1, 1, 2, 10, 0, 0, 0, 0, 0);
    drive(1, 1, 2, 11, 0, 0, 0, 0, 0);
    drive(1, 1, 2, 12, 0, 0, 0, 1, 0);
    drive(1, 3, 4, 13, 0, 0, 0, 0, 0);
    drive(1, 3, 4, 14, 0, 0, 0, 0, 0);
    drive(1, 5, 6, 15, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0);

    for (int n = 0; n < 3000; n++) begin
      cycle($urandom_range(0, 299) == 0,
            $urandom_range(0, 3) != 0,
            6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)),
            $urandom_range(0, 4) != 0, $urandom_range(0, 4) != 0, $urandom_range(0, 5) != 0,
            $urandom_range(0, 2) != 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 5) != 0, 6'($urandom_range(0, 7)),
            $urandom_range(0, 2) == 0, $urandom_range(0, 5) != 0, 6'($urandom_range(0, 7)),
            $urandom_range(0, 39) == 0);
    end
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
    @(negedge clock);
    #4;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dispatch_busytable.md
Name: dispatch_busytable

Overview:
- Producer for the issue queue enqueue port: sits between rename and the issue queue.
- Keeps a per-physical-register busy table, tracks ready state through wakeups, and drives the enqueue handshake.
- Buffers renamed instructions in a 2-entry FIFO.
- Computes src1/src2 state bits so the queue receives correct readiness even when a writeback coincides with enqueue.

Parameters:
PREG_NUM, 64, number of physical registers; busy table depth
PREG_W, 6, physical register index width (log2 PREG_NUM)
PAYLOAD_W, 256, opaque bundle (pc, imm, op types, ls_size, robidx, old_prd, ...) passed through unchanged

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  renamed instruction valid
in_ready  out  1  FIFO can accept
in_prs1  in  PREG_W  physical source 1
in_prs2  in  PREG_W  physical source 2
in_prd  in  PREG_W  physical destination
in_src1_is_reg  in  1  src1 read from register file
in_src2_is_reg  in  1  src2 read from register file
in_need_to_wb  in  1  instruction writes prd
in_payload  in  PAYLOAD_W  opaque fields
iq_valid  out  1  enqueue valid to issue queue
iq_ready  in  1  issue queue slot free
iq_prs1 / iq_prs2 / iq_prd  out  PREG_W each  head entry registers
iq_src1_is_reg / iq_src2_is_reg / iq_need_to_wb  out  1 each  head entry flags
iq_src1_state / iq_src2_state  out  1 each  1 = operand still pending
iq_payload  out  PAYLOAD_W  head entry payload
writeback0_valid / writeback0_need_to_wb  in  1 each  writeback port 0
writeback0_prd  in  PREG_W  writeback port 0 destination
writeback1_valid / writeback1_need_to_wb  in  1 each  writeback port 1
writeback1_prd  in  PREG_W  writeback port 1 destination
flush  in  1  drop all buffered instructions

Behaviour:
- One clock. Reset is synchronous and active-high, sampled on the clock's rising edge.
- Reset:
  - busy table all 0; FIFO empty; count=0.
  - in_ready=1, iq_valid=0; all iq_* data outputs 0.
- wbK_hit = writebackK_valid & writebackK_need_to_wb & (writebackK_prd != 0).
- Accept: in_valid & in_ready. in_ready = (count < 2), derived from registered count only; it does not depend on iq_ready the same cycle.
- Src state at accept: srcN_state = in_srcN_is_reg & (in_prsN != 0) & busy[in_prsN] & ~(wb0_hit & wb0_prd==in_prsN) & ~(wb1_hit & wb1_prd==in_prsN). The state is stored in the FIFO entry.
- Busy set: on accept with in_need_to_wb & in_prd != 0, busy[in_prd] <= 1 at the end of that cycle.
- Busy clear: each wbK_hit clears busy[writebackK_prd].
- Same-cycle set and clear on the same index: set wins.
- busy[0] is hard-wired 0.
- Buffered wakeup: every cycle, each valid FIFO entry clears srcN_state when srcN_is_reg and prsN matches a wbK_hit.
- Output: iq_* is driven combinationally from the FIFO head. iq_valid = (count != 0).
- iq_srcN_state = stored head state & ~(same-cycle wbK_hit match on head prsN). The issue queue captures the enqueue and processes wakeups in the same edge but cannot wake a slot written that edge, so this mask is required.
- Dequeue: iq_valid & iq_ready pops the head.
- Simultaneous accept and dequeue: allowed; count unchanged. When count=2, no accept.
- Latency: an instruction accepted in cycle N is presented with iq_valid=1 in cycle N+1 at earliest.
- FIFO uses 1-bit read and write pointers that wrap 1 -> 0.
- flush:
  - count <= 0, pointers <= 0; the accept in that cycle is ignored and busy is not set for it.
  - Busy table is untouched; busy recovery is owned by rename/ROB walk.
- Two writebacks to the same prd in one cycle are legal; clear once.
- in_payload and all iq_* fields are passed through bit-exact.

Test Plan:
- Reset then accept {prs1=5, prs2=0, prd=7, is_reg=1/1, need_to_wb=1} with busy empty -> cycle N+1: iq_valid=1, src1_state=0, src2_state=0; busy[7]=1 afterwards.
- Accept A (prd=7), then B (prs1=7) -> B presented with src1_state=1. Then wb0{valid=1, need_to_wb=1, prd=7} while B is held with iq_ready=0 -> next cycle B shows src1_state=0 and busy[7]=0.
- B at head with stored src1_state=1, iq_ready=1, wb1 prd=7 in the same cycle -> iq_src1_state=0 combinationally that cycle.
- iq_ready=0, push 3 instructions -> in_ready=0 after the 2nd. Release iq_ready -> entries drain in order, one per cycle; payloads match; pointer wrap verified over 6 instructions.
- Accept with prd=9 and wb0 prd=9 in the same cycle -> busy[9]=1. Accept with prd=0 -> busy[0] stays 0. Src with prs1=0, is_reg=1 -> state 0.
- Two entries buffered, assert flush together with in_valid (prd=12) -> next cycle iq_valid=0, count=0, busy[12] unchanged. Synchronous reset mid-stream -> all outputs return to reset values the next cycle.
